uart_transmitter: RTL

Serialises one UART frame per accepted word onto Tx, driven by the same 16x-baud clock as the receive path. Frame format comes from the same configuration signals the receiver uses: 1..9 data bits, optional even/odd parity, 1 or 2 stop bits. A looped-back Tx→Rx pair with identical configuration must reproduce the transmitted word with frame_valid asserted. Sits between the command/pixel source and the serial pin.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_transmitter_if.sv | 27 ++
 rtl/uart_parity_calc.sv | 13 +
 rtl/uart_transmitter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame limits, parity codes.
// Used by the transmitter and reusable by the receive path.
package uart_pkg;

    localparam int TICKS_PER_BIT_DEF = 16;
    localparam int MAX_DATA_BITS     = 9;
    localparam int DEFAULT_DATA_BITS = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Out-of-range lengths fall back to the common 8-bit frame
    function automatic logic [3:0] eff_len(input logic [3:0] fl);
        if (fl == 4'd0 || fl > 4'(MAX_DATA_BITS))
            return 4'(DEFAULT_DATA_BITS);
        return fl;
    endfunction

    function automatic logic [MAX_DATA_BITS-1:0] len_mask(input logic [3:0] len);
        logic [MAX_DATA_BITS-1:0] m;
        for (int i = 0; i < MAX_DATA_BITS; i++)
            m[i] = (4'(i) < len);
        return m;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Word/config handshake between the data source and the UART transmitter.
// master = source side, slave = transmitter side.
interface uart_transmitter_if;
    import uart_pkg::*;

    logic [MAX_DATA_BITS-1:0] data_in;
    logic                     data_valid;
    logic                     parity;
    logic                     parity_type;
    logic                     stop_bits;
    logic [3:0]               frame_length;
    logic                     ready;
    logic                     tx_done;

    modport master (
        output data_in, data_valid, parity, parity_type,
        output stop_bits, frame_length,
        input  ready, tx_done
    );

    modport slave (
        input  data_in, data_valid, parity, parity_type,
        input  stop_bits, frame_length,
        output ready, tx_done
    );

endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity generator over an already-masked data word.
// Shared by transmit (generation) and receive (check).
module uart_parity_calc
    import uart_pkg::*;
(
    input  logic [MAX_DATA_BITS-1:0] data_i,
    input  logic                     type_i,
    output logic                     parity_o
);

    assign parity_o = (^data_i) ^ (type_i == PARITY_ODD);

endmodule

// File: rtl/uart_transmitter.sv
// UART frame serialiser on the 16x-baud clock: start, 1..9 data bits,
// optional parity, 1 or 2 stop bits. Tx is registered and idles high.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF
) (
    input  logic                clk_16bd,
    input  logic                rst,
    uart_transmitter_if.slave   bus,
    output logic                Tx
);

    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);

    logic [2:0]               state_q, state_d;
    logic [TW-1:0]            tick_q, tick_d;
    logic [3:0]               bit_q, bit_d;
    logic                     stop_q, stop_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic                     par_en_q, par_en_d;
    logic                     par_bit_q, par_bit_d;
    logic                     stop2_q, stop2_d;
    logic [3:0]               len_q, len_d;
    logic                     tx_q, tx_d;
    logic                     done_q, done_d;

    logic [3:0]               len_in;
    logic [MAX_DATA_BITS-1:0] masked_in;
    logic                     par_in;
    logic                     accept;
    logic                     tick_last;

    assign len_in    = eff_len(bus.frame_length);
    assign masked_in = bus.data_in & len_mask(len_in);
    assign accept    = (state_q == S_IDLE) && bus.data_valid;
    assign tick_last = (tick_q == TICK_LAST);

    uart_parity_calc u_par (
        .data_i   (masked_in),
        .type_i   (bus.parity_type),
        .parity_o (par_in)
    );

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q + TW'(1);
        bit_d     = bit_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        len_d     = len_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (accept) begin
                    state_d   = S_START;
                    shift_d   = masked_in;
                    par_en_d  = bus.parity;
                    par_bit_d = par_in;
                    stop2_d   = bus.stop_bits;
                    len_d     = len_in;
                    bit_d     = 4'd0;
                    stop_d    = 1'b0;
                end
            end
            S_START: begin
                if (tick_last) begin
                    state_d = S_DATA;
                    tick_d  = '0;
                end
            end
            S_DATA: begin
                if (tick_last) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == len_q - 4'd1)
                        state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (tick_last) begin
                    state_d = S_STOP;
                    tick_d  = '0;
                end
            end
            S_STOP: begin
                if (tick_last) begin
                    tick_d = '0;
                    if (stop2_q && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    // Line level follows the next state so Tx drops on the accept edge
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= 4'd0;
            stop_q    <= 1'b0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            len_q     <= 4'd0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            len_q     <= len_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready   = (state_q == S_IDLE);
    assign bus.tx_done = done_q;
    assign Tx          = tx_q;

endmodule
